// File: rtl/prbs_tx.sv
// PRBS9 transmitter: one NRZ symbol per N_PHASES clocks with valid strobe.
// Build option PRBS_TX_ERR_INJECT_EN adds periodic single-bit error injection.
module prbs_tx #(
  parameter int         NB_OUTPUT  = 8,
  parameter int         NBF_OUTPUT = 7,
  parameter int         N_PHASES   = 4,
  parameter logic [8:0] SEED       = 9'h1AA,
  parameter int         ERR_PERIOD = 1000
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_restart,
  output logic signed [NB_OUTPUT-1:0]   o_data,
  output logic                          o_valid,
  output logic                          o_bit,
  output logic [$clog2(N_PHASES)-1:0]   o_phase,
  output logic [31:0]                   o_bit_cnt,
  output logic                          o_err_inj
);

  localparam int PW = $clog2(N_PHASES);
  localparam logic [NB_OUTPUT-1:0] POS =
    {1'b0, {(NB_OUTPUT-1){1'b1}}};
  localparam logic [NB_OUTPUT-1:0] NEG =
    ~POS + NB_OUTPUT'(1);

  if (N_PHASES < 2 || N_PHASES > 16 ||
      (N_PHASES & (N_PHASES - 1)) != 0) begin : g_bad_phases
    $error("prbs_tx: N_PHASES must be a power of two in 2..16");
  end
  if (ERR_PERIOD < 2 || ERR_PERIOD > 65535) begin : g_bad_period
    $error("prbs_tx: ERR_PERIOD out of range 2..65535");
  end
  if (SEED == 9'd0) begin : g_bad_seed
    $error("prbs_tx: SEED must be nonzero");
  end
  if (NBF_OUTPUT >= NB_OUTPUT) begin : g_bad_frac
    $error("prbs_tx: NBF_OUTPUT must be below NB_OUTPUT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [8:0]      prbs;
  logic [8:0]      prbs_nxt;
  logic [PW-1:0]   phase_cnt;
  logic [PW-1:0]   phase_nxt;
  logic            run_cyc;
  logic            clr;
  logic            emit;
  logic            inject;
  logic            bit_tx;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_en)  state_nxt = RUN;
      RUN:     if (!i_en) state_nxt = HOLD;
      HOLD:    if (i_en)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (i_restart) state_nxt = IDLE;
  end

  // Advance only while actually running; dropping i_en freezes at once.
  always_comb begin
    clr     = i_restart | (state == IDLE);
    run_cyc = (state == RUN) & i_en & ~i_restart;
    emit    = run_cyc & (phase_cnt == '0);
    bit_tx  = prbs[8] ^ inject;
    prbs_nxt = {prbs[7:0], prbs[8] ^ prbs[4]};
    if (phase_cnt == PW'(N_PHASES - 1)) begin
      phase_nxt = '0;
    end else begin
      phase_nxt = phase_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      prbs      <= SEED;
      phase_cnt <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_bit     <= 1'b0;
      o_phase   <= '0;
      o_bit_cnt <= '0;
    end else begin
      o_valid <= emit;
      if (clr) begin
        prbs      <= SEED;
        phase_cnt <= '0;
        o_bit_cnt <= '0;
      end else if (run_cyc) begin
        phase_cnt <= phase_nxt;
        o_phase   <= phase_cnt;
        if (emit) begin
          o_bit  <= bit_tx;
          o_data <= bit_tx ? NEG : POS;
          prbs   <= prbs_nxt;
          if (o_bit_cnt != 32'hFFFF_FFFF) begin
            o_bit_cnt <= o_bit_cnt + 32'd1;
          end
        end
      end
    end
  end

`ifdef PRBS_TX_ERR_INJECT_EN
  logic [15:0] err_cnt;

  // Inversion hits only the emitted bit; the LFSR keeps the clean sequence.
  assign inject = (err_cnt == 16'(ERR_PERIOD - 1));

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      err_cnt   <= '0;
      o_err_inj <= 1'b0;
    end else begin
      o_err_inj <= emit & inject;
      if (i_restart) begin
        err_cnt <= '0;
      end else if (emit) begin
        err_cnt <= inject ? 16'd0 : err_cnt + 16'd1;
      end
    end
  end
`else
  assign inject    = 1'b0;
  assign o_err_inj = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_tx.sv
// Directed bench for prbs_tx: vector table plus multi-cycle sequences.
// Honors PRBS_TX_ERR_INJECT_EN (then ERR_PERIOD=10).
module tb_prbs_tx;

`ifdef PRBS_TX_ERR_INJECT_EN
  localparam int ERR_P = 10;
  localparam bit INJ   = 1'b1;
`else
  localparam int ERR_P = 1000;
  localparam bit INJ   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_restart;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_bit;
  logic [1:0]  o_phase;
  logic [31:0] o_bit_cnt;
  logic        o_err_inj;

  prbs_tx #(
    .NB_OUTPUT  (8),
    .NBF_OUTPUT (7),
    .N_PHASES   (4),
    .SEED       (9'h1AA),
    .ERR_PERIOD (ERR_P)
  ) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_restart (i_restart),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_bit     (o_bit),
    .o_phase   (o_phase),
    .o_bit_cnt (o_bit_cnt),
    .o_err_inj (o_err_inj)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [7:0] d;
  } vec_t;

  vec_t       vec [9];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] g;
  int         n_emit;
  logic       last_bit;

  function automatic logic [7:0] map_bit(input logic b);
    return b ? 8'h81 : 8'h7F;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    g      = 9'h1AA;
    n_emit = 0;
  endtask

  // One clock; every strobe is scored against the golden PRBS9 stream.
  task automatic step();
    logic gb;
    logic inj;
    @(posedge clk);
    #1;
    if (o_valid) begin
      n_emit++;
      gb = g[8];
      g  = {g[7:0], g[8] ^ g[4]};
      inj = INJ && ((n_emit % ERR_P) == 0);
      last_bit = gb ^ inj;
      check("bit", o_bit, last_bit);
      check("data", o_data, map_bit(last_bit));
      check("err_inj", o_err_inj, inj);
    end else begin
      check("err_inj_quiet", o_err_inj, 0);
    end
  endtask

  task automatic wait_first();
    int lat = 0;
    do begin
      step();
      lat++;
    end while (!o_valid && lat < 10);
    check("first_valid_lat", lat, 2);
  endtask

  task automatic next_valid();
    int k = 0;
    do begin
      step();
      k++;
    end while (!o_valid && k < 16);
    check("valid_timeout", o_valid, 1);
  endtask

  task automatic apply_table(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_valid();
      check($sformatf("vec%0d_bit", i), o_bit, vec[i].b);
      check($sformatf("vec%0d_data", i), o_data, vec[i].d);
      check($sformatf("vec%0d_cnt", i), o_bit_cnt, i + 1);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_bit"}, o_bit, 0);
    check({tag, "_phase"}, o_phase, 0);
    check({tag, "_cnt"}, o_bit_cnt, 0);
    check({tag, "_inj"}, o_err_inj, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{1'b1, 8'h81};
    vec[1] = '{1'b1, 8'h81};
    vec[2] = '{1'b0, 8'h7F};
    vec[3] = '{1'b1, 8'h81};
    vec[4] = '{1'b0, 8'h7F};
    vec[5] = '{1'b1, 8'h81};
    vec[6] = '{1'b0, 8'h7F};
    vec[7] = '{1'b1, 8'h81};
    vec[8] = '{1'b0, 8'h7F};
    last_bit = 1'b0;

    // reset state and idle hold
    i_rst     = 1'b1;
    i_en      = 1'b0;
    i_restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    reset_model();
    check_zero("rst");
    step();
    step();
    check("idle_valid", o_valid, 0);
    check("idle_cnt", o_bit_cnt, 0);

    // first symbols after enable
    i_en = 1'b1;
    wait_first();
    apply_table(9);

    // restart, then one full period of continuous run
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check("rs1_cnt", o_bit_cnt, 0);
    reset_model();
    wait_first();
    for (int k = 0; k < 2044; k++) begin
      check("phase", o_phase, k % 4);
      check("valid_pat", o_valid, (k % 4) == 0);
      if (k < 2043) step();
    end
    check("cnt_511", o_bit_cnt, 511);
    step();
    check("bit512_valid", o_valid, 1);
    check("bit512_eq_bit1", o_bit, 1);
    check("cnt_512", o_bit_cnt, 512);

    // freeze for 7 cycles at phase 2
    step();
    step();
    check("hold_pre_phase", o_phase, 2);
    i_en = 1'b0;
    repeat (7) begin
      step();
      check("hold_valid", o_valid, 0);
      check("hold_phase", o_phase, 2);
      check("hold_bit", o_bit, last_bit);
      check("hold_data", o_data, map_bit(last_bit));
      check("hold_cnt", o_bit_cnt, 512);
    end
    i_en = 1'b1;
    repeat (80) step();
    check("resume_cnt", o_bit_cnt, 532);

    // restart at bit 100 of a fresh stream
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    reset_model();
    wait_first();
    begin
      int k = 0;
      while (n_emit < 100 && k < 1000) begin
        step();
        k++;
      end
    end
    check("reach_bit100", o_bit_cnt, 100);
    step();
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check("rs_valid", o_valid, 0);
    check("rs_cnt", o_bit_cnt, 0);
    check("rs_data_held", o_data, map_bit(last_bit));
    reset_model();
    wait_first();
    apply_table(4);

    // long run: injected errors only where expected
    begin
      int k = 0;
      while (n_emit < 1000 && k < 5000) begin
        step();
        k++;
      end
    end
    check("cnt_1000", o_bit_cnt, 1000);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    i_rst = 1'b1;
    #1;
    check_zero("arst");
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    reset_model();
    wait_first();
    apply_table(9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
